// File: rtl/per_port_distributor_pkg.sv
// per_port_distributor_pkg
//   Shared definitions for the per-port distributor: FSM state encoding and
//   default stream widths / destination-field position.
package per_port_distributor_pkg;

  localparam int DEF_DATA_W    = 256;
  localparam int DEF_USER_W    = 128;
  localparam int DEF_NUM_PORTS = 5;
  localparam int DEF_DST_POS   = 24;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUTE = 2'd1,
    ST_DROP  = 2'd2
  } state_e;

endpackage

// File: rtl/per_port_out_slice.sv
// per_port_out_slice
//   Two-entry registered FIFO holding one output port's beats.
//   Write side : wr_en + beat fields; full is taken from the registered count,
//                so a full slice refuses writes even in a cycle it is read.
//   Read side  : AXI4-Stream style m_tvalid/m_tready; outputs come straight
//                from storage flops (no input-to-output combinational path).
module per_port_out_slice
  import per_port_distributor_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int USER_W = DEF_USER_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [DATA_W-1:0]   wr_tdata,
  input  logic [DATA_W/8-1:0] wr_tstrb,
  input  logic [USER_W-1:0]   wr_tuser,
  input  logic                wr_tlast,
  output logic                full,
  output logic [DATA_W-1:0]   m_tdata,
  output logic [DATA_W/8-1:0] m_tstrb,
  output logic [USER_W-1:0]   m_tuser,
  output logic                m_tlast,
  output logic                m_tvalid,
  input  logic                m_tready
);

  localparam int STRB_W = DATA_W / 8;
  localparam int W      = DATA_W + STRB_W + USER_W + 1;

  logic [W-1:0] mem_q [2];
  logic [W-1:0] mem_d [2];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         do_wr, do_rd;

  assign full     = (cnt_q == 2'd2);
  assign m_tvalid = (cnt_q != 2'd0);
  assign {m_tdata, m_tstrb, m_tuser, m_tlast} = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    do_wr    = wr_en & ~full;
    do_rd    = m_tvalid & m_tready;
    if (do_wr) mem_d[wr_ptr_q] = {wr_tdata, wr_tstrb, wr_tuser, wr_tlast};
    wr_ptr_d = wr_ptr_q ^ do_wr;
    rd_ptr_d = rd_ptr_q ^ do_rd;
    cnt_d    = cnt_q + {1'b0, do_wr} - {1'b0, do_rd};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      for (int i = 0; i < 2; i++) mem_q[i] <= mem_d[i];
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/per_port_distributor.sv
// per_port_distributor
//   Demultiplexes one AXI4-Stream into C_M_NUM_OUTPUT_IF output streams using
//   a one-hot destination field in tuser taken from each packet's first beat.
//   Unicast, all-or-nothing multicast, and drop of packets with no destination.
//   Ports:
//     axi_aclk, axi_reset, sw_rst      clock, sync active-high resets (ORed)
//     s_axis_*                         input stream
//     m_axis_*_grp                     packed per-port output streams, port i
//                                      at slice [W*i +: W]
//   Optional: define PER_PORT_DISTRIBUTOR_STATS_EN to add pkt_cnt_grp
//   (per-port packets written) and drop_cnt (packets dropped) counters.
module per_port_distributor
  import per_port_distributor_pkg::*;
#(
  parameter int C_M_AXIS_DATA_WIDTH  = DEF_DATA_W,
  parameter int C_S_AXIS_DATA_WIDTH  = DEF_DATA_W,
  parameter int C_M_AXIS_TUSER_WIDTH = DEF_USER_W,
  parameter int C_S_AXIS_TUSER_WIDTH = DEF_USER_W,
  parameter int C_M_NUM_OUTPUT_IF    = DEF_NUM_PORTS,
  parameter int C_DST_POS            = DEF_DST_POS
) (
  input  logic                                                 axi_aclk,
  input  logic                                                 axi_reset,
  input  logic                                                 sw_rst,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]                       s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]                     s_axis_tstrb,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]                      s_axis_tuser,
  input  logic                                                 s_axis_tvalid,
  output logic                                                 s_axis_tready,
  input  logic                                                 s_axis_tlast,
  output logic [C_M_NUM_OUTPUT_IF*C_M_AXIS_DATA_WIDTH-1:0]     m_axis_tdata_grp,
  output logic [C_M_NUM_OUTPUT_IF*C_M_AXIS_DATA_WIDTH/8-1:0]   m_axis_tstrb_grp,
  output logic [C_M_NUM_OUTPUT_IF*C_M_AXIS_TUSER_WIDTH-1:0]    m_axis_tuser_grp,
  output logic [C_M_NUM_OUTPUT_IF-1:0]                         m_axis_tvalid_grp,
  input  logic [C_M_NUM_OUTPUT_IF-1:0]                         m_axis_tready_grp,
  output logic [C_M_NUM_OUTPUT_IF-1:0]                         m_axis_tlast_grp
`ifdef PER_PORT_DISTRIBUTOR_STATS_EN
  ,
  output logic [C_M_NUM_OUTPUT_IF*32-1:0]                      pkt_cnt_grp,
  output logic [31:0]                                          drop_cnt
`endif
);

  localparam int N   = C_M_NUM_OUTPUT_IF;
  localparam int DW  = C_M_AXIS_DATA_WIDTH;
  localparam int SW  = C_M_AXIS_DATA_WIDTH / 8;
  localparam int UW  = C_M_AXIS_TUSER_WIDTH;

  logic         rst;
  logic [N-1:0] dst;
  logic [N-1:0] full, space;
  logic [N-1:0] wr_sel, wr_en;
  logic         rdy_int, acc;
  state_e       state_q, state_d;
  logic [N-1:0] mask_q, mask_d;

  assign rst   = axi_reset | sw_rst;
  // Only the N-bit field is looked at; higher tuser bits never route.
  assign dst   = s_axis_tuser[C_DST_POS +: N];
  assign space = ~full;

  // FSM: state register
  always_ff @(posedge axi_aclk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
    end
  end

  // FSM: outputs. Ready is the AND of space over the selected ports, so a
  // multicast beat lands in every selected slice or in none.
  always_comb begin
    rdy_int = 1'b0;
    wr_sel  = '0;
    case (state_q)
      ST_IDLE: begin
        if (dst == '0) begin
          rdy_int = 1'b1;
        end else begin
          wr_sel  = dst;
          rdy_int = &(space | ~dst);
        end
      end
      ST_ROUTE: begin
        wr_sel  = mask_q;
        rdy_int = &(space | ~mask_q);
      end
      ST_DROP:  rdy_int = 1'b1;
      default:  rdy_int = 1'b0;
    endcase
  end

  assign s_axis_tready = rdy_int & ~rst;
  assign acc           = s_axis_tvalid & s_axis_tready;
  assign wr_en         = wr_sel & {N{acc}};

  // FSM: next state
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    case (state_q)
      ST_IDLE: begin
        if (acc) begin
          if (dst == '0) begin
            state_d = s_axis_tlast ? ST_IDLE : ST_DROP;
          end else begin
            mask_d  = dst;
            state_d = s_axis_tlast ? ST_IDLE : ST_ROUTE;
          end
        end
      end
      ST_ROUTE: if (acc && s_axis_tlast) state_d = ST_IDLE;
      ST_DROP:  if (acc && s_axis_tlast) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  for (genvar i = 0; i < N; i++) begin : g_slice
    per_port_out_slice #(
      .DATA_W (DW),
      .USER_W (UW)
    ) u_slice (
      .clk      (axi_aclk),
      .rst      (rst),
      .wr_en    (wr_en[i]),
      .wr_tdata (s_axis_tdata),
      .wr_tstrb (s_axis_tstrb),
      .wr_tuser (s_axis_tuser),
      .wr_tlast (s_axis_tlast),
      .full     (full[i]),
      .m_tdata  (m_axis_tdata_grp[DW*i +: DW]),
      .m_tstrb  (m_axis_tstrb_grp[SW*i +: SW]),
      .m_tuser  (m_axis_tuser_grp[UW*i +: UW]),
      .m_tlast  (m_axis_tlast_grp[i]),
      .m_tvalid (m_axis_tvalid_grp[i]),
      .m_tready (m_axis_tready_grp[i])
    );
  end

`ifdef PER_PORT_DISTRIBUTOR_STATS_EN
  logic [N-1:0][31:0] pkt_cnt_q, pkt_cnt_d;
  logic [31:0]        drop_cnt_q, drop_cnt_d;

  always_comb begin
    pkt_cnt_d  = pkt_cnt_q;
    drop_cnt_d = drop_cnt_q;
    for (int i = 0; i < N; i++)
      if (wr_en[i] && s_axis_tlast) pkt_cnt_d[i] = pkt_cnt_q[i] + 32'd1;
    // A drop is counted once, on its first beat.
    if (acc && state_q == ST_IDLE && dst == '0) drop_cnt_d = drop_cnt_q + 32'd1;
  end

  always_ff @(posedge axi_aclk) begin
    if (rst) begin
      pkt_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      pkt_cnt_q  <= pkt_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign pkt_cnt_grp = pkt_cnt_q;
  assign drop_cnt    = drop_cnt_q;
`endif

endmodule

// File: tb/tb_per_port_distributor.sv
module tb_per_port_distributor;
  localparam int N  = 5;
  localparam int DW = 256;
  localparam int SW = 32;
  localparam int UW = 128;
  localparam int DP = 24;
  localparam int LW = 448;

  logic                 clk = 1'b0;
  logic                 axi_reset, sw_rst;
  logic [DW-1:0]        s_axis_tdata;
  logic [SW-1:0]        s_axis_tstrb;
  logic [UW-1:0]        s_axis_tuser;
  logic                 s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic [N*DW-1:0]      m_axis_tdata_grp;
  logic [N*SW-1:0]      m_axis_tstrb_grp;
  logic [N*UW-1:0]      m_axis_tuser_grp;
  logic [N-1:0]         m_axis_tvalid_grp, m_axis_tready_grp, m_axis_tlast_grp;
`ifdef PER_PORT_DISTRIBUTOR_STATS_EN
  logic [N*32-1:0]      pkt_cnt_grp;
  logic [31:0]          drop_cnt;
`endif

  always #5 clk = ~clk;

  per_port_distributor dut (
    .axi_aclk          (clk),
    .axi_reset         (axi_reset),
    .sw_rst            (sw_rst),
    .s_axis_tdata      (s_axis_tdata),
    .s_axis_tstrb      (s_axis_tstrb),
    .s_axis_tuser      (s_axis_tuser),
    .s_axis_tvalid     (s_axis_tvalid),
    .s_axis_tready     (s_axis_tready),
    .s_axis_tlast      (s_axis_tlast),
    .m_axis_tdata_grp  (m_axis_tdata_grp),
    .m_axis_tstrb_grp  (m_axis_tstrb_grp),
    .m_axis_tuser_grp  (m_axis_tuser_grp),
    .m_axis_tvalid_grp (m_axis_tvalid_grp),
    .m_axis_tready_grp (m_axis_tready_grp),
    .m_axis_tlast_grp  (m_axis_tlast_grp)
`ifdef PER_PORT_DISTRIBUTOR_STATS_EN
    ,
    .pkt_cnt_grp       (pkt_cnt_grp),
    .drop_cnt          (drop_cnt)
`endif
  );

  typedef struct packed {
    logic [DW-1:0] d;
    logic [SW-1:0] s;
    logic [UW-1:0] u;
    logic          l;
  } beat_t;

  // Reference model: each port is a queue of beats in flight (capacity 2),
  // plus the routing decision held for the packet in progress.
  beat_t        mq [N][$];
  bit           m_busy, m_drop;
  logic [N-1:0] m_mask;
  int           mdl_drops;
  int           mdl_pkts [N];

  int checks = 0, errors = 0;
  int rx_cnt [N];
  bit acc_dut;
  bit rnd_rdy = 0;
  int cyc = 0;

  task automatic check(input string nm, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic logic [UW-1:0] mk_user(input logic [N-1:0] dst);
    logic [UW-1:0] u;
    u = {$urandom, $urandom, $urandom, $urandom};
    u[DP +: N] = dst;
    return u;
  endfunction

  function automatic logic exp_ready();
    logic [N-1:0] sel;
    if (axi_reset || sw_rst) return 1'b0;
    if (!m_busy) begin
      sel = s_axis_tuser[DP +: N];
      if (sel == '0) return 1'b1;
    end else if (m_drop) begin
      return 1'b1;
    end else begin
      sel = m_mask;
    end
    for (int i = 0; i < N; i++)
      if (sel[i] && mq[i].size() >= 2) return 1'b0;
    return 1'b1;
  endfunction

  // One clock: check DUT against the model, then advance the model across
  // the edge. Entered and left 1 time unit after a rising edge.
  task automatic cycle();
    logic         er, rst, tv, tl;
    logic [N-1:0] pop, sel;
    beat_t        b, o;
    if (rnd_rdy)
      for (int i = 0; i < N; i++) m_axis_tready_grp[i] = ($urandom_range(0, 3) != 0);
    #1;
    rst = axi_reset | sw_rst;
    er  = exp_ready();
    check("s_tready", LW'(s_axis_tready), LW'(er));
    for (int i = 0; i < N; i++) begin
      check($sformatf("tvalid%0d", i), LW'(m_axis_tvalid_grp[i]), LW'(mq[i].size() != 0));
      if (mq[i].size() != 0) begin
        o = {m_axis_tdata_grp[DW*i +: DW], m_axis_tstrb_grp[SW*i +: SW],
             m_axis_tuser_grp[UW*i +: UW], m_axis_tlast_grp[i]};
        check($sformatf("beat%0d", i), LW'(o), LW'(mq[i][0]));
      end
      pop[i] = (mq[i].size() != 0) && m_axis_tready_grp[i];
      if (m_axis_tvalid_grp[i] && m_axis_tready_grp[i]) rx_cnt[i]++;
    end
    acc_dut = s_axis_tvalid && s_axis_tready;
    tv  = s_axis_tvalid;
    tl  = s_axis_tlast;
    b   = {s_axis_tdata, s_axis_tstrb, s_axis_tuser, s_axis_tlast};
    sel = s_axis_tuser[DP +: N];
    @(posedge clk);
    cyc++;
    if (rst) begin
      for (int i = 0; i < N; i++) begin mq[i].delete(); mdl_pkts[i] = 0; end
      m_busy = 0; m_drop = 0; m_mask = '0; mdl_drops = 0;
    end else begin
      for (int i = 0; i < N; i++) if (pop[i]) void'(mq[i].pop_front());
      if (tv && er) begin
        if (!m_busy) begin
          m_drop = (sel == '0);
          m_mask = sel;
          m_busy = !tl;
          if (sel == '0) mdl_drops++;
        end else begin
          sel = m_drop ? '0 : m_mask;
          if (tl) m_busy = 0;
        end
        for (int i = 0; i < N; i++)
          if (sel[i]) begin
            mq[i].push_back(b);
            if (tl) mdl_pkts[i]++;
          end
      end
    end
    #1;
  endtask

  task automatic send_beat(input logic [N-1:0] dst, input logic last);
    int k;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    s_axis_tstrb  = $urandom;
    s_axis_tuser  = mk_user(dst);
    s_axis_tlast  = last;
    k = 0;
    do begin
      cycle();
      k++;
    end while (!acc_dut && k < 200);
    if (!acc_dut) begin
      errors++;
      $display("FAIL send_timeout: got no accept expected accept within 200 cycles");
    end
    s_axis_tvalid = 1'b0;
  endtask

  task automatic idle(input int n);
    s_axis_tvalid = 1'b0;
    repeat (n) cycle();
  endtask

  task automatic clr_rx();
    for (int i = 0; i < N; i++) rx_cnt[i] = 0;
  endtask

  typedef struct {
    logic [N-1:0] dst0;
    logic [N-1:0] dstn;
    int           nb;
    logic [N-1:0] exp_ports;
  } vec_t;

  vec_t tbl [6];
  int   c0;

  initial begin
    // {first-beat dst, later-beat dst, beats, ports expected to receive all beats}
    tbl[0] = '{5'b00100, 5'b00100, 3, 5'b00100};  // unicast
    tbl[1] = '{5'b00000, 5'b00000, 4, 5'b00000};  // drop
    tbl[2] = '{5'b00010, 5'b01000, 3, 5'b00010};  // routing latched on first beat
    tbl[3] = '{5'b10001, 5'b00000, 2, 5'b10001};  // multicast
    tbl[4] = '{5'b00001, 5'b00001, 1, 5'b00001};  // single beat
    tbl[5] = '{5'b11111, 5'b00010, 2, 5'b11111};  // broadcast

    axi_reset = 1; sw_rst = 0;
    s_axis_tvalid = 0; s_axis_tlast = 0; s_axis_tdata = '0; s_axis_tstrb = '0; s_axis_tuser = '0;
    m_axis_tready_grp = '1;
    m_busy = 0; m_drop = 0; m_mask = '0; mdl_drops = 0;
    for (int i = 0; i < N; i++) mdl_pkts[i] = 0;
    clr_rx();
    repeat (2) @(posedge clk);
    #1;
    cycle(); cycle();
    check("reset_tvalid", LW'(m_axis_tvalid_grp), LW'(0));
    axi_reset = 0;
    idle(2);

    // Table-driven packets, all ports ready.
    for (int t = 0; t < 6; t++) begin
      clr_rx();
      for (int b = 0; b < tbl[t].nb; b++)
        send_beat((b == 0) ? tbl[t].dst0 : tbl[t].dstn, b == tbl[t].nb - 1);
      idle(4);
      for (int i = 0; i < N; i++)
        check($sformatf("tbl%0d_rx%0d", t, i), LW'(rx_cnt[i]), LW'(tbl[t].exp_ports[i] ? tbl[t].nb : 0));
`ifdef PER_PORT_DISTRIBUTOR_STATS_EN
      check($sformatf("tbl%0d_drop_cnt", t), LW'(drop_cnt), LW'(mdl_drops));
      for (int i = 0; i < N; i++)
        check($sformatf("tbl%0d_pkt_cnt%0d", t, i), LW'(pkt_cnt_grp[32*i +: 32]), LW'(mdl_pkts[i]));
`endif
    end

    // Multicast stall: port 4 stops reading, so its slice fills after 2 beats.
    clr_rx();
    m_axis_tready_grp = 5'b01111;
    send_beat(5'b10001, 0);
    send_beat(5'b10001, 0);
    s_axis_tvalid = 1'b1; s_axis_tlast = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cycle();
      check("mc_stall_accept", LW'(acc_dut), LW'(0));
    end
    check("mc_port0_rx", LW'(rx_cnt[0]), LW'(2));
    m_axis_tready_grp = '1;
    send_beat(5'b10001, 0);
    send_beat(5'b10001, 1);
    idle(4);
    check("mc_port0_total", LW'(rx_cnt[0]), LW'(4));
    check("mc_port4_total", LW'(rx_cnt[4]), LW'(4));

    // Back-to-back: 1-beat packet to port 0 then 2-beat packet to port 3.
    clr_rx();
    c0 = cyc;
    send_beat(5'b00001, 1);
    send_beat(5'b01000, 0);
    send_beat(5'b01000, 1);
    check("b2b_cycles", LW'(cyc - c0), LW'(3));
    idle(3);
    check("b2b_port0", LW'(rx_cnt[0]), LW'(1));
    check("b2b_port3", LW'(rx_cnt[3]), LW'(2));

    // Reset mid-packet with data parked in the slice.
    clr_rx();
    m_axis_tready_grp = '0;
    send_beat(5'b00100, 0);
    s_axis_tvalid = 1'b1; s_axis_tlast = 1'b0;
    axi_reset = 1;
    cycle();
    axi_reset = 0;
    s_axis_tvalid = 1'b0;
    cycle();
    check("rst_mid_tvalid", LW'(m_axis_tvalid_grp), LW'(0));
    m_axis_tready_grp = '1;
    send_beat(5'b00010, 0);
    send_beat(5'b00010, 1);
    idle(3);
    check("rst_mid_port1", LW'(rx_cnt[1]), LW'(2));
    check("rst_mid_port2", LW'(rx_cnt[2]), LW'(0));

    // Random traffic with random back-pressure, gaps and one soft reset.
    rnd_rdy = 1;
    for (int p = 0; p < 300; p++) begin
      logic [N-1:0] d0;
      int len;
      d0  = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
      len = $urandom_range(1, 4);
      for (int b = 0; b < len; b++) begin
        if ($urandom_range(0, 3) == 0) begin
          s_axis_tvalid = 1'b0;
          s_axis_tuser  = mk_user(N'($urandom));
          cycle();
        end
        if (p == 150 && b == 1) begin
          sw_rst = 1;
          s_axis_tvalid = 1'b0;
          cycle();
          sw_rst = 0;
          break;
        end
        send_beat((b == 0) ? d0 : N'($urandom), b == len - 1);
      end
    end
    rnd_rdy = 0;
    m_axis_tready_grp = '1;
    idle(5);
    for (int i = 0; i < N; i++)
      check($sformatf("drain_empty%0d", i), LW'(m_axis_tvalid_grp[i]), LW'(0));
`ifdef PER_PORT_DISTRIBUTOR_STATS_EN
    check("rand_drop_cnt", LW'(drop_cnt), LW'(mdl_drops));
    for (int i = 0; i < N; i++)
      check($sformatf("rand_pkt_cnt%0d", i), LW'(pkt_cnt_grp[32*i +: 32]), LW'(mdl_pkts[i]));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
